vga_scan_driver: RTL and testbench
==================================

// Module: vga_scan_driver
// PURPOSE
//  Display-side end of the pixel interface: generates the 640x480@60 raster.
//  Drives DrawX/DrawY to the colour mapper and samples the Red/Green/Blue it returns.
//  Registers that colour, blanked outside the visible area, onto the VGA pins with
//  matching hs/vs/de. Sits between the colour mapper and the board's VGA DAC.
// PARAMETERS
//  CLK_DIV    2    Clk cycles per pixel (pixel_en period), >=1
//  H_VISIBLE  640  visible pixels per line
//  H_FP       16   horizontal front porch, pixels
//  H_SYNC     96   horizontal sync width, pixels
//  H_BP       48   horizontal back porch, pixels (line total H_TOT = 800)
//  V_VISIBLE  480  visible lines per frame
//  V_FP       10   vertical front porch, lines
//  V_SYNC     2    vertical sync width, lines
//  V_BP       33   vertical back porch, lines (frame total V_TOT = 525)
// PORTS
//  Clk          in   1   system clock; single clock domain
//  Reset_n      in   1   asynchronous, active-low reset
//  Red          in   8   colour-mapper red for current DrawX/DrawY (combinational)
//  Green        in   8   colour-mapper green
//  Blue         in   8   colour-mapper blue
//  DrawX        out  10  current horizontal count 0..H_TOT-1 (registered)
//  DrawY        out  10  current vertical count 0..V_TOT-1 (registered)
//  pixel_en     out  1   one-Clk strobe, once every CLK_DIV Clk cycles
//  frame_start  out  1   one-Clk strobe on the pixel_en where counters wrap to (0,0)
//  VGA_R        out  8   registered red to DAC
//  VGA_G        out  8   registered green
//  VGA_B        out  8   registered blue
//  hs           out  1   horizontal sync, active low
//  vs           out  1   vertical sync, active low
//  de           out  1   display enable, high when VGA_R/G/B is a visible pixel
// BEHAVIOUR
//  - Reset (async, Reset_n=0): divider=0, DrawX=DrawY=0, pixel_en=0, frame_start=0,
//    VGA_R/G/B=0, hs=1, vs=1, de=0. Release is synchronous to Clk. The first
//    pixel_en occurs CLK_DIV Clk cycles after release.
//  - Divider counts 0..CLK_DIV-1 and asserts pixel_en for one Clk at terminal count.
//    CLK_DIV=1: pixel_en is held high continuously.
//  - Only on pixel_en, stage 1 captures from the current (DrawX,DrawY):
//    vis = DrawX<H_VISIBLE && DrawY<V_VISIBLE;
//    VGA_R/G/B <= vis ? Red/Green/Blue : 0;
//    de <= vis;
//    hs <= ~(DrawX in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1]) (656..751);
//    vs <= ~(DrawY in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1]) (490..491).
//  - On the same pixel_en, counters advance:
//    DrawX wraps H_TOT-1 -> 0; DrawY increments only on that wrap;
//    DrawY wraps V_TOT-1 -> 0.
//  - Latency: pins reflect DrawX/DrawY exactly one pixel period after they are driven.
//    hs, vs, de and RGB are always mutually aligned. Between pixel_en strobes all
//    outputs hold.
//  - frame_start is asserted with the pixel_en on which (DrawX,DrawY)=(H_TOT-1,V_TOT-1)
//    and is low otherwise.
//  - Red/Green/Blue only need to settle within one pixel period. Values outside
//    the visible area are ignored, so pins are 0 in the porches and during sync.
//  - Reset asserted mid-frame: all state returns to reset values immediately. The
//    next frame restarts at (0,0) with no partial-line output.
// CONFIGURATION
//  VGA_TEST_PATTERN_EN defined:
//   - Adds input test_mode (1 bit).
//   - When test_mode=1, stage 1 ignores Red/Green/Blue and captures 8 vertical colour
//     bars, each 80 px wide: bar = DrawX[9:0]/80 (0..7),
//     VGA_R={8{bar[2]}}, VGA_G={8{bar[1]}}, VGA_B={8{bar[0]}}.
//   - Blanking and timing are unchanged.
//   - test_mode is sampled only on pixel_en.
//  Not defined: no test_mode port; pins always carry mapper colour.
// TESTING
//  1. Reset_n=0 then release, CLK_DIV=2 -> pixel_en every 2nd Clk; hs=vs=1, de=0,
//     VGA_*=0 until first strobe.
//  2. Count line -> hs low for exactly 96 pixel_en strobes starting when stage-1
//     sees DrawX=656; line period 800 strobes.
//  3. Count frame -> vs low for 2 lines (DrawY 490,491); frame period 420000 strobes;
//     frame_start pulses once per frame.
//  4. Drive Red=8'hAB, Green=8'h00, Blue=8'h11 constant -> VGA_* equal them exactly
//     when de=1 (307200 per frame) and 0 elsewhere.
//  5. Pulse Reset_n=0 at DrawX=300, DrawY=200 -> all outputs reset asynchronously;
//     after release DrawX=DrawY=0 and timing matches scenario 2.
//  6. VGA_TEST_PATTERN_EN, test_mode=1 -> DrawX=0..79 gives RGB=000000,
//     DrawX=560..639 gives FFFFFF; blanking still 0.

Source files
------------

// File: rtl/vga_scan_driver.sv
// 640x480@60 raster driver: pixel strobe, DrawX/DrawY scan counters and one registered pin stage.
// Optional macro VGA_TEST_PATTERN_EN adds a test_mode input selecting eight vertical colour bars.
module vga_scan_driver #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       Clk,
  input  logic       Reset_n,
`ifdef VGA_TEST_PATTERN_EN
  input  logic       test_mode,
`endif
  input  logic [7:0] Red,
  input  logic [7:0] Green,
  input  logic [7:0] Blue,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       pixel_en,
  output logic       frame_start,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       hs,
  output logic       vs,
  output logic       de
);

  localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] X_LAST = 10'(H_TOT - 1);
  localparam logic [9:0] Y_LAST = 10'(V_TOT - 1);
  localparam logic [9:0] X_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] Y_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_q;
  logic             pen_q;
  logic [9:0]       x_q, y_q;

  logic             vis_p0, hs_p0, vs_p0;
  logic [23:0]      src_p0, rgb_p0;

  logic [7:0]       r_p1, g_p1, b_p1;
  logic             hs_p1, vs_p1, de_p1;

  function automatic logic [23:0] blank_rgb(input logic vis, input logic [23:0] rgb);
    return vis ? rgb : 24'h0;
  endfunction

`ifdef VGA_TEST_PATTERN_EN
  function automatic logic [23:0] bar_rgb(input logic [9:0] x);
    logic [9:0] bar;
    bar = x / 10'd80;
    return {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
  endfunction
`endif

  // pixel strobe: registered so the first strobe lands CLK_DIV clocks after release
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_q <= '0;
      pen_q <= 1'b0;
    end else begin
      div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      pen_q <= (div_q == DIV_LAST);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (pen_q) begin
      if (x_q == X_LAST) begin
        x_q <= '0;
        y_q <= (y_q == Y_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_q <= x_q + 10'd1;
      end
    end
  end

  // stage p0: decode the position currently presented to the colour mapper
  always_comb begin
    vis_p0 = (x_q < X_VIS) && (y_q < Y_VIS);
    hs_p0  = !((x_q >= HS_BEG) && (x_q <= HS_END));
    vs_p0  = !((y_q >= VS_BEG) && (y_q <= VS_END));
    src_p0 = {Red, Green, Blue};
`ifdef VGA_TEST_PATTERN_EN
    if (test_mode) src_p0 = bar_rgb(x_q);
`endif
    rgb_p0 = blank_rgb(vis_p0, src_p0);
  end

  // stage p1: pins, one pixel period behind DrawX/DrawY
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_p1  <= '0;
      g_p1  <= '0;
      b_p1  <= '0;
      hs_p1 <= 1'b1;
      vs_p1 <= 1'b1;
      de_p1 <= 1'b0;
    end else if (pen_q) begin
      {r_p1, g_p1, b_p1} <= rgb_p0;
      hs_p1 <= hs_p0;
      vs_p1 <= vs_p0;
      de_p1 <= vis_p0;
    end
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign pixel_en    = pen_q;
  assign frame_start = pen_q && (x_q == X_LAST) && (y_q == Y_LAST);
  assign VGA_R       = r_p1;
  assign VGA_G       = g_p1;
  assign VGA_B       = b_p1;
  assign hs          = hs_p1;
  assign vs          = vs_p1;
  assign de          = de_p1;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Bench for vga_scan_driver with a shrunken raster (25x11) so several frames fit in a short run.
module tb_vga_scan_driver;

  localparam int CLK_DIV   = 2;
  localparam int H_VISIBLE = 16;
  localparam int H_FP      = 2;
  localparam int H_SYNC    = 4;
  localparam int H_BP      = 3;
  localparam int V_VISIBLE = 6;
  localparam int V_FP      = 1;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 2;
  localparam int H_TOT     = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT     = V_VISIBLE + V_FP + V_SYNC + V_BP;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [7:0] Red = 8'h0, Green = 8'h0, Blue = 8'h0;
  logic [9:0] DrawX, DrawY;
  logic       pixel_en, frame_start;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic       hs, vs, de;

  vga_scan_driver #(
    .CLK_DIV(CLK_DIV), .H_VISIBLE(H_VISIBLE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VISIBLE(V_VISIBLE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Red(Red), .Green(Green), .Blue(Blue),
    .DrawX(DrawX), .DrawY(DrawY), .pixel_en(pixel_en), .frame_start(frame_start),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .hs(hs), .vs(vs), .de(de)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  int c = 0;
  int m_x, m_y;
  bit m_pen;
  logic [7:0] e_r, e_g, e_b;
  logic e_hs, e_vs, e_de;
  int cnt_fs, cnt_hs, cnt_vs, cnt_de;

  typedef struct {
    int tx, ty;
    logic [7:0] r, g, b;
    logic [7:0] er, eg, eb;
    logic ede, ehs, evs;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_DrawX"}, int'(DrawX), 0);
    chk({tag, "_DrawY"}, int'(DrawY), 0);
    chk({tag, "_pixel_en"}, int'(pixel_en), 0);
    chk({tag, "_frame_start"}, int'(frame_start), 0);
    chk({tag, "_rgb"}, int'({VGA_R, VGA_G, VGA_B}), 0);
    chk({tag, "_hs"}, int'(hs), 1);
    chk({tag, "_vs"}, int'(vs), 1);
    chk({tag, "_de"}, int'(de), 0);
  endtask

  task automatic model_reset();
    c = 0;
    {e_r, e_g, e_b} = 24'h0;
    e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0;
  endtask

  // Reference: position is a pure function of elapsed clocks since release.
  task automatic step(input int tx, input int ty, input logic [7:0] fr, fg, fb, output bit hit);
    int n;
    bit vis;
    @(negedge Clk);
    c++;
    n = (c - 1) / CLK_DIV;
    m_x = n % H_TOT;
    m_y = (n / H_TOT) % V_TOT;
    m_pen = (c >= CLK_DIV) && (c % CLK_DIV == 0);
    chk("pixel_en", int'(pixel_en), int'(m_pen));
    chk("DrawX", int'(DrawX), m_x);
    chk("DrawY", int'(DrawY), m_y);
    chk("frame_start", int'(frame_start), int'(m_pen && m_x == H_TOT-1 && m_y == V_TOT-1));
    chk("VGA_R", int'(VGA_R), int'(e_r));
    chk("VGA_G", int'(VGA_G), int'(e_g));
    chk("VGA_B", int'(VGA_B), int'(e_b));
    chk("hs", int'(hs), int'(e_hs));
    chk("vs", int'(vs), int'(e_vs));
    chk("de", int'(de), int'(e_de));
    if (m_pen) begin
      cnt_fs += int'(frame_start);
      cnt_hs += int'(!hs);
      cnt_vs += int'(!vs);
      cnt_de += int'(de);
    end
    hit = m_pen && m_x == tx && m_y == ty;
    if (hit) {Red, Green, Blue} = {fr, fg, fb};
    else     {Red, Green, Blue} = 24'($urandom());
    if (m_pen) begin
      vis  = (m_x < H_VISIBLE) && (m_y < V_VISIBLE);
      e_r  = vis ? Red : 8'h0;
      e_g  = vis ? Green : 8'h0;
      e_b  = vis ? Blue : 8'h0;
      e_de = vis;
      e_hs = !(m_x >= H_VISIBLE + H_FP && m_x < H_VISIBLE + H_FP + H_SYNC);
      e_vs = !(m_y >= V_VISIBLE + V_FP && m_y < V_VISIBLE + V_FP + V_SYNC);
    end
  endtask

  task automatic goto_hit(input int tx, input int ty, input logic [7:0] r, g, b);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 4 * H_TOT * V_TOT * CLK_DIV && !hit; i++) step(tx, ty, r, g, b, hit);
    if (!hit) chk("goto_timeout", 0, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit dummy;
    tbl[0]  = '{0, 0,  8'hAB, 8'h00, 8'h11, 8'hAB, 8'h00, 8'h11, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{15, 0, 8'h12, 8'h34, 8'h56, 8'h12, 8'h34, 8'h56, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{16, 0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{18, 2, 8'hFF, 8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{21, 3, 8'h55, 8'h55, 8'h55, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{22, 3, 8'h55, 8'h55, 8'h55, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{15, 5, 8'h01, 8'h02, 8'h03, 8'h01, 8'h02, 8'h03, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{5, 7,  8'h77, 8'h77, 8'h77, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{19, 8, 8'h99, 8'h88, 8'h77, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{24, 10, 8'hEE, 8'hDD, 8'hCC, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{3, 9,  8'h44, 8'h33, 8'h22, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{7, 1,  8'hC3, 8'h3C, 8'hA5, 8'hC3, 8'h3C, 8'hA5, 1'b1, 1'b1, 1'b1};

    // power-on reset held for a few clocks
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    chk_reset("por");
    Reset_n = 1'b1;
    model_reset();

    for (int i = 0; i < 12; i++) begin
      goto_hit(tbl[i].tx, tbl[i].ty, tbl[i].r, tbl[i].g, tbl[i].b);
      step(-1, -1, 8'h0, 8'h0, 8'h0, dummy);
      chk($sformatf("tbl%0d_rgb", i), int'({VGA_R, VGA_G, VGA_B}), int'({tbl[i].er, tbl[i].eg, tbl[i].eb}));
      chk($sformatf("tbl%0d_de", i), int'(de), int'(tbl[i].ede));
      chk($sformatf("tbl%0d_hs", i), int'(hs), int'(tbl[i].ehs));
      chk($sformatf("tbl%0d_vs", i), int'(vs), int'(tbl[i].evs));
    end

    // mid-frame asynchronous reset, asserted between clock edges
    goto_hit(10, 4, 8'h5A, 8'hA5, 8'h3C);
    step(-1, -1, 8'h0, 8'h0, 8'h0, dummy);
    #2 Reset_n = 1'b0;
    #1 chk_reset("async");
    @(negedge Clk);
    @(negedge Clk);
    chk_reset("held");
    Reset_n = 1'b1;
    model_reset();

    // two full frames of counting from the restart
    cnt_fs = 0; cnt_hs = 0; cnt_vs = 0; cnt_de = 0;
    for (int i = 0; i < 2 * H_TOT * V_TOT * CLK_DIV; i++) step(-1, -1, 8'h0, 8'h0, 8'h0, dummy);
    chk("frame_start_count", cnt_fs, 2);
    chk("hs_low_count", cnt_hs, 88);
    chk("vs_low_count", cnt_vs, 100);
    chk("de_count", cnt_de, 192);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
